// File: rtl/shift_rotate_engine.sv
// Digit-granular shift/rotate register: parallel load plus a multi-cycle
// command that moves the register one digit per clock for AMOUNT clocks.
//
// state | meaning
// IDLE  | waiting; LOAD/START accepted
// RUN   | one digit step per edge, counter counting down
// FIN   | DONE pulse; LOAD/START still accepted
module shift_rotate_engine #(
  parameter int DIGIT_W = 4,
  parameter int DIGITS  = 16,
  parameter logic [DIGIT_W*DIGITS-1:0] INIT = 64'h41217CF9DAB30832
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        LOAD,
  input  logic [DIGIT_W*DIGITS-1:0]   DATA_IN,
  input  logic                        START,
  input  logic                        DIR,
  input  logic [1:0]                  MODE,
  input  logic [$clog2(DIGITS):0]     AMOUNT,
  input  logic [DIGIT_W-1:0]          FILL,
  output logic [DIGIT_W*DIGITS-1:0]   OUT_SEQ,
  output logic                        BUSY,
  output logic                        DONE
);
  localparam int W  = DIGIT_W * DIGITS;
  localparam int AW = $clog2(DIGITS) + 1;
  localparam logic [AW-1:0] AMT_MAX = AW'(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t               state, state_nxt;
  logic                 accept, load_go, start_go;
  logic [AW-1:0]        amt_sat, cnt;
  logic                 dir_q;
  logic [1:0]           mode_q;
  logic [DIGIT_W-1:0]   fill_q, fill_digit;
  logic                 rotate;
  logic [W-1:0]         out_q, step_val;

  assign accept   = (state != S_RUN);
  assign load_go  = accept & LOAD;
  assign start_go = accept & START & ~LOAD;
  assign amt_sat  = (AMOUNT > AMT_MAX) ? AMT_MAX : AMOUNT;
  assign OUT_SEQ  = out_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (cnt == AW'(1)) state_nxt = S_FIN;
      end
      default: begin
        if (load_go)       state_nxt = S_IDLE;
        else if (start_go) state_nxt = (amt_sat == '0) ? S_FIN : S_RUN;
        else               state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    BUSY = (state == S_RUN);
    DONE = (state == S_FIN);
  end

  // MODE 00 and 11 both rotate; only MODE 10 uses the latched fill digit.
  always_comb begin
    rotate     = (mode_q == 2'b00) || (mode_q == 2'b11);
    fill_digit = (mode_q == 2'b10) ? fill_q : '0;
    if (dir_q)
      step_val = {out_q[W-DIGIT_W-1:0], rotate ? out_q[W-1:W-DIGIT_W] : fill_digit};
    else
      step_val = {rotate ? out_q[DIGIT_W-1:0] : fill_digit, out_q[W-1:DIGIT_W]};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_q  <= INIT;
      cnt    <= '0;
      dir_q  <= 1'b0;
      mode_q <= 2'b00;
      fill_q <= '0;
    end else if (load_go) begin
      out_q <= DATA_IN;
    end else if (start_go) begin
      dir_q  <= DIR;
      mode_q <= MODE;
      fill_q <= FILL;
      cnt    <= amt_sat;
    end else if (state == S_RUN) begin
      out_q <= step_val;
      cnt   <= cnt - AW'(1);
    end
  end

endmodule

// File: tb/tb_shift_rotate_engine.sv
// Bench for shift_rotate_engine: digit-array reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_shift_rotate_engine;
  localparam logic [63:0] INIT_V = 64'h41217CF9DAB30832;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        LOAD = 1'b0;
  logic [63:0] DATA_IN = '0;
  logic        START = 1'b0;
  logic        DIR = 1'b0;
  logic [1:0]  MODE = 2'b00;
  logic [4:0]  AMOUNT = '0;
  logic [3:0]  FILL = '0;
  logic [63:0] OUT_SEQ;
  logic        BUSY, DONE;

  shift_rotate_engine dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .DATA_IN(DATA_IN), .START(START),
    .DIR(DIR), .MODE(MODE), .AMOUNT(AMOUNT), .FILL(FILL),
    .OUT_SEQ(OUT_SEQ), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Reference model: value, steps still owed, and the DONE pulse.
  logic [63:0] m_val;
  int          m_left;
  bit          m_done;
  logic        c_dir;
  logic [1:0]  c_mode;
  logic [3:0]  c_fill;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] step1(input logic [63:0] v, input logic dir,
                                        input logic [1:0] mode, input logic [3:0] fill);
    logic [3:0] d[16];
    logic [3:0] edge_digit, fd;
    logic [63:0] r;
    bit rot;
    for (int i = 0; i < 16; i++) d[i] = v[i*4 +: 4];
    rot = (mode == 2'd0) || (mode == 2'd3);
    fd  = (mode == 2'd2) ? fill : 4'h0;
    if (!dir) begin
      edge_digit = d[0];
      for (int i = 0; i < 15; i++) d[i] = d[i+1];
      d[15] = rot ? edge_digit : fd;
    end else begin
      edge_digit = d[15];
      for (int i = 15; i > 0; i--) d[i] = d[i-1];
      d[0] = rot ? edge_digit : fd;
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = d[i];
    return r;
  endfunction

  task automatic model_edge();
    int n;
    if (!RST_N) begin
      m_val = INIT_V; m_left = 0; m_done = 1'b0;
    end else if (m_left > 0) begin
      m_val = step1(m_val, c_dir, c_mode, c_fill);
      m_left--;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (LOAD) m_val = DATA_IN;
      else if (START) begin
        n = (int'(AMOUNT) > 16) ? 16 : int'(AMOUNT);
        c_dir = DIR; c_mode = MODE; c_fill = FILL;
        if (n == 0) m_done = 1'b1;
        else m_left = n;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("out_seq", OUT_SEQ, m_val);
      check("busy", 64'(BUSY), 64'(m_left > 0));
      check("done", 64'(DONE), 64'(m_done));
    end
  end

  task automatic do_reset();
    RST_N = 1'b0; LOAD = 1'b0; START = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  task automatic issue(input logic dir, input logic [1:0] mode, input logic [4:0] amt,
                       input logic [3:0] fill);
    START = 1'b1; DIR = dir; MODE = mode; AMOUNT = amt; FILL = fill;
    tick();
    START = 1'b0;
    DIR = ~dir; MODE = ~mode; AMOUNT = 5'd7; FILL = ~fill;
  endtask

  task automatic wait_busy(output int cycles);
    int guard = 0;
    cycles = 0;
    while (BUSY && guard < 40) begin
      cycles++; guard++;
      tick();
    end
    if (guard >= 40) check("busy_timeout", 64'(guard), 64'd0);
  endtask

  int bc;

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_out", OUT_SEQ, INIT_V);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);

    issue(1'b0, 2'b00, 5'd1, 4'h0);
    check("rr1_busy", 64'(BUSY), 64'd1);
    tick();
    check("rr1_out", OUT_SEQ, 64'h241217CF9DAB3083);
    check("rr1_done", 64'(DONE), 64'd1);
    tick();
    check("rr1_done_clr", 64'(DONE), 64'd0);

    do_reset();
    issue(1'b1, 2'b00, 5'd4, 4'h0);
    wait_busy(bc);
    check("rl4_cycles", 64'(bc), 64'd4);
    check("rl4_out", OUT_SEQ, 64'h7CF9DAB308324121);
    check("rl4_done", 64'(DONE), 64'd1);

    do_reset();
    issue(1'b0, 2'b01, 5'd3, 4'hA);
    wait_busy(bc);
    check("zr3_out", OUT_SEQ, 64'h00041217CF9DAB30);

    do_reset();
    issue(1'b1, 2'b10, 5'd2, 4'hF);
    wait_busy(bc);
    check("fl2_out", OUT_SEQ, 64'h217CF9DAB30832FF);

    LOAD = 1'b1; DATA_IN = 64'h0123456789ABCDEF; START = 1'b1; AMOUNT = 5'd3;
    tick();
    LOAD = 1'b0; START = 1'b0;
    check("coll_out", OUT_SEQ, 64'h0123456789ABCDEF);
    check("coll_busy", 64'(BUSY), 64'd0);
    check("coll_done", 64'(DONE), 64'd0);

    issue(1'b0, 2'b00, 5'd5, 4'h0);
    START = 1'b1; LOAD = 1'b1; DATA_IN = 64'hFFFF_0000_FFFF_0000; AMOUNT = 5'd1;
    repeat (3) tick();
    START = 1'b0; LOAD = 1'b0;
    wait_busy(bc);
    check("run_ign_cycles", 64'(bc), 64'd2);
    check("run_ign_out", OUT_SEQ, 64'hBCDEF0123456789A);

    issue(1'b0, 2'b00, 5'd0, 4'h0);
    check("amt0_done", 64'(DONE), 64'd1);
    check("amt0_out", OUT_SEQ, 64'hBCDEF0123456789A);

    do_reset();
    issue(1'b0, 2'b00, 5'd5, 4'h0);
    tick(); tick();
    do_reset();
    check("midrst_out", OUT_SEQ, INIT_V);
    check("midrst_busy", 64'(BUSY), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_nodone", 64'(DONE), 64'd0);
    end

    issue(1'b0, 2'b00, 5'd20, 4'h0);
    wait_busy(bc);
    check("sat_cycles", 64'(bc), 64'd16);
    check("sat_out", OUT_SEQ, INIT_V);
    check("sat_done", 64'(DONE), 64'd1);

    issue(1'b1, 2'b01, 5'd31, 4'h0);
    wait_busy(bc);
    check("sat_shift_out", OUT_SEQ, 64'h0);

    for (int i = 0; i < 4000; i++) begin
      RST_N   = ($urandom_range(0, 99) >= 2);
      LOAD    = ($urandom_range(0, 99) < 10);
      START   = ($urandom_range(0, 99) < 30);
      DIR     = 1'($urandom);
      MODE    = 2'($urandom);
      AMOUNT  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31))
                                            : 5'($urandom_range(0, 6));
      FILL    = 4'($urandom);
      DATA_IN = {$urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule
